// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: fetches code from the bus into an 8-byte ring indexed by address[2:0].
// Optional 8-bit bus mode (one byte per ack, exact byte addresses): define NEC_PREFETCH_BUS8_EN.
module nec_prefetch #(
  parameter int ADDR_WIDTH     = 20,
  parameter int FETCH_MIN_FREE = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [15:0]           ps,
  input  logic [15:0]           pc,
  input  logic [15:0]           new_pc,
  input  logic                  set_pc,
  output logic [7:0][7:0]       ipq,
  output logic [3:0]            ipq_len,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [15:0]           bus_data
);

  // Handshake: bus_req rises with bus_addr and both stay stable until a ce-qualified
  // cycle with bus_ack high completes the transfer; bus_req drops on that same edge.
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISCARD} state_e;

`ifdef NEC_PREFETCH_BUS8_EN
  localparam logic [3:0] MIN_FREE = 4'd1;
`else
  localparam logic [3:0] MIN_FREE = 4'(FETCH_MIN_FREE);
`endif

  state_e                state_q, state_d;
  logic [15:0]           fetch_pc_q, fetch_pc_d;
  logic [7:0][7:0]       ipq_q, ipq_d;
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;

  logic [15:0]           fill;
  logic [3:0]            free;
  logic                  can_issue;
  logic                  issue;
  logic                  take_data;
  logic [19:0]           phys;
  logic [19:0]           phys_bus;
  logic [2:0]            slot;
  logic [2:0]            slot_n;

  // A pc outside [fetch_pc-8, fetch_pc] means the decoder ran ahead; report empty.
  assign fill      = fetch_pc_q - pc;
  assign ipq_len   = (fill > 16'd8) ? 4'd0 : fill[3:0];
  assign free      = 4'd8 - ipq_len;
  assign can_issue = (free >= MIN_FREE);

  assign phys   = {ps, 4'b0000} + {4'b0000, fetch_pc_q};
`ifdef NEC_PREFETCH_BUS8_EN
  assign phys_bus = phys;
`else
  assign phys_bus = {phys[19:1], 1'b0};
`endif

  assign slot   = fetch_pc_q[2:0];
  assign slot_n = slot + 3'd1;

  assign ipq      = ipq_q;
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!set_pc && can_issue) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_ack)     state_d = ST_IDLE;
        else if (set_pc) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (bus_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue      = (state_q == ST_IDLE) && !set_pc && can_issue;
    take_data  = (state_q == ST_REQ) && bus_ack && !set_pc;
    fetch_pc_d = fetch_pc_q;
    ipq_d      = ipq_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;

    if (issue) begin
      bus_req_d  = 1'b1;
      bus_addr_d = ADDR_WIDTH'(phys_bus);
    end else if ((state_q != ST_IDLE) && bus_ack) begin
      bus_req_d = 1'b0;
    end

    if (set_pc) begin
      fetch_pc_d = new_pc;
    end else if (take_data) begin
`ifdef NEC_PREFETCH_BUS8_EN
      ipq_d[slot] = bus_data[7:0];
      fetch_pc_d  = fetch_pc_q + 16'd1;
`else
      // An odd fetch_pc fetched the enclosing word; only its high byte is new.
      if (fetch_pc_q[0]) begin
        ipq_d[slot] = bus_data[15:8];
        fetch_pc_d  = fetch_pc_q + 16'd1;
      end else begin
        ipq_d[slot]   = bus_data[7:0];
        ipq_d[slot_n] = bus_data[15:8];
        fetch_pc_d    = fetch_pc_q + 16'd2;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= 16'h0000;
      ipq_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
    end else if (ce) begin
      fetch_pc_q <= fetch_pc_d;
      ipq_q      <= ipq_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
    end
  end

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed bench for nec_prefetch: request addresses checked by a scoreboard monitor,
// queue contents and fill level checked at fixed points of the stimulus.
module tb_nec_prefetch;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ce;
  logic [15:0]     ps;
  logic [15:0]     pc;
  logic [15:0]     new_pc;
  logic            set_pc;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic            bus_req;
  logic [19:0]     bus_addr;
  logic            bus_ack;
  logic [15:0]     bus_data;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_addr;
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  nec_prefetch #(.ADDR_WIDTH(20), .FETCH_MIN_FREE(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .ps       (ps),
    .pc       (pc),
    .new_pc   (new_pc),
    .set_pc   (set_pc),
    .ipq      (ipq),
    .ipq_len  (ipq_len),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_ack  (bus_ack),
    .bus_data (bus_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new bus request must match the next expected address.
  always @(negedge clk) begin
    if (bus_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_addr: unexpected request got %0h expected none", bus_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        check("bus_addr", {44'd0, bus_addr}, {44'd0, exp_addr});
      end
    end
    req_prev = bus_req;
  end

  task automatic wait_req(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: bus_req timeout got 0 expected 1", name);
  endtask

  task automatic ack_word(input string name, input logic [15:0] d);
    wait_req(name);
    bus_ack  = 1'b1;
    bus_data = d;
    @(posedge clk);
    #1 bus_ack = 1'b0;
  endtask

  task automatic flush(input logic [15:0] npc);
    @(posedge clk);
    #1;
    set_pc = 1'b1;
    new_pc = npc;
    pc     = npc;
    @(posedge clk);
    #1 set_pc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    ce       = 1'b1;
    ps       = 16'h1000;
    pc       = 16'h0100;
    new_pc   = 16'h0100;
    set_pc   = 1'b1;
    bus_ack  = 1'b0;
    bus_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bus_req", {63'd0, bus_req}, 64'd0);
    check("reset_bus_addr", {44'd0, bus_addr}, 64'd0);
    check("reset_ipq_len", {60'd0, ipq_len}, 64'd0);
    check("reset_ipq", ipq, 64'd0);

    // First fetch after flush to 0100
    exp_q.push_back(20'h10100);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 set_pc = 1'b0;
    exp_q.push_back(20'h10102);
    ack_word("t1_ack", 16'hBBAA);
    @(negedge clk);
    check("t1_slot0", {56'd0, ipq[0]}, 64'hAA);
    check("t1_slot1", {56'd0, ipq[1]}, 64'hBB);
    check("t1_len", {60'd0, ipq_len}, 64'd2);

    // Fill to full with pc held
    exp_q.push_back(20'h10104);
    ack_word("t3_ack1", 16'hDDCC);
    exp_q.push_back(20'h10106);
    ack_word("t3_ack2", 16'hFFEE);
    ack_word("t3_ack3", 16'h2211);
    @(negedge clk);
    check("t3_len_full", {60'd0, ipq_len}, 64'd8);
    check("t3_ipq_full", ipq, 64'h2211FFEEDDCCBBAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_no_req_full", {63'd0, bus_req}, 64'd0);
    end
    exp_q.push_back(20'h10108);
    @(posedge clk);
    #1 pc = 16'h0102;
    @(posedge clk);
    @(negedge clk);
    check("t3_req_after_consume", {63'd0, bus_req}, 64'd1);
    check("t3_len_after_consume", {60'd0, ipq_len}, 64'd6);

    // Flush while a request is outstanding: request held, data dropped
    flush(16'h0400);
    @(negedge clk);
    check("t4_req_held", {63'd0, bus_req}, 64'd1);
    check("t4_len", {60'd0, ipq_len}, 64'd0);
    @(negedge clk);
    check("t4_req_still_held", {63'd0, bus_req}, 64'd1);
    exp_q.push_back(20'h10400);
    ack_word("t4_discard_ack", 16'h5A5A);
    @(negedge clk);
    check("t4_len_after_discard", {60'd0, ipq_len}, 64'd0);
    check("t4_ipq_unchanged", ipq, 64'h2211FFEEDDCCBBAA);

    // Flush and ack in the same cycle: data dropped, straight back to idle
    exp_q.push_back(20'h10202);
    wait_req("t4b_req");
    set_pc   = 1'b1;
    new_pc   = 16'h0203;
    pc       = 16'h0203;
    bus_ack  = 1'b1;
    bus_data = 16'h7777;
    @(posedge clk);
    #1;
    set_pc  = 1'b0;
    bus_ack = 1'b0;
    @(negedge clk);
    check("t4b_req_dropped", {63'd0, bus_req}, 64'd0);
    check("t4b_len", {60'd0, ipq_len}, 64'd0);
    check("t4b_ipq_unchanged", ipq, 64'h2211FFEEDDCCBBAA);

    // Odd start: only the high byte of the word lands in slot 3
    exp_q.push_back(20'h10204);
    ack_word("t2_ack", 16'h3412);
    @(negedge clk);
    check("t2_len", {60'd0, ipq_len}, 64'd1);
    check("t2_ipq", ipq, 64'h2211FFEE34CCBBAA);

    // Segment wrap from FFFE to 0000
    flush(16'hFFFE);
    exp_q.push_back(20'h1FFFE);
    ack_word("t5_discard_ack", 16'h9999);
    exp_q.push_back(20'h10000);
    ack_word("t5_ack", 16'h6655);
    @(negedge clk);
    check("t5_len_wrap", {60'd0, ipq_len}, 64'd2);
    check("t5_ipq", ipq, 64'h6655FFEE34CCBBAA);

    // Reset in the middle of a request, then a stray ack
    wait_req("t6_req");
    reset_n = 1'b0;
    set_pc  = 1'b1;
    new_pc  = 16'h0000;
    pc      = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    check("t6_req_dropped", {63'd0, bus_req}, 64'd0);
    check("t6_addr_reset", {44'd0, bus_addr}, 64'd0);
    check("t6_ipq_reset", ipq, 64'd0);
    bus_ack  = 1'b1;
    bus_data = 16'hEEEE;
    exp_q.push_back(20'h10000);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    set_pc  = 1'b0;
    @(negedge clk);
    check("t6_len_stray", {60'd0, ipq_len}, 64'd0);
    check("t6_ipq_stray", ipq, 64'd0);
    check("t6_req_idle", {63'd0, bus_req}, 64'd0);
    repeat (3) @(negedge clk);
    check("t6_req_resumes", {63'd0, bus_req}, 64'd1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
